// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller:
// stall vector patterns, register address width and the multi-cycle FSM states.
package id_hazard_ctrl_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned STALL_W        = 6;

    // Bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_HAZ  = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MC   = 6'b001111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode/writeback/flush signal bundle between the pipeline and the hazard controller.
interface id_hazard_ctrl_if;
    import id_hazard_ctrl_pkg::*;

    logic                      id_valid_in;
    logic                      id_rd_en1_in;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr1_in;
    logic                      id_rd_en2_in;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr2_in;
    logic                      id_wr_en_in;
    logic [REG_ADDR_WIDTH-1:0] id_wr_addr_in;
    logic                      id_mc_req_in;
    logic                      wb_wr_en_in;
    logic [REG_ADDR_WIDTH-1:0] wb_wr_addr_in;
    logic                      flush_in;
    logic [STALL_W-1:0]        stall_out;
    logic                      id_issue_out;
    logic                      hazard_out;
    logic                      mc_busy_out;
    logic                      mc_done_out;

    modport master (
        output id_valid_in, id_rd_en1_in, id_rd_addr1_in, id_rd_en2_in, id_rd_addr2_in,
               id_wr_en_in, id_wr_addr_in, id_mc_req_in, wb_wr_en_in, wb_wr_addr_in, flush_in,
        input  stall_out, id_issue_out, hazard_out, mc_busy_out, mc_done_out
    );

    modport slave (
        input  id_valid_in, id_rd_en1_in, id_rd_addr1_in, id_rd_en2_in, id_rd_addr2_in,
               id_wr_en_in, id_wr_addr_in, id_mc_req_in, wb_wr_en_in, wb_wr_addr_in, flush_in,
        output stall_out, id_issue_out, hazard_out, mc_busy_out, mc_done_out
    );

endinterface

// File: rtl/id_hazard_ctrl_mc_seq.sv
// Multi-cycle EX sequencer: holds BUSY for exactly MC_CYCLES cycles, then a one-cycle DONE.
module id_hazard_ctrl_mc_seq
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MC_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic flush,
    output logic busy,
    output logic done
);

    localparam int unsigned     CNT_W   = $clog2(MC_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(MC_CYCLES);

    mc_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MC_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = MC_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MC_IDLE: begin
                    if (start) begin
                        state_d = MC_BUSY;
                        cnt_d   = CNT_LD;
                    end
                end
                MC_BUSY: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_d = MC_DONE;
                end
                MC_DONE: begin
                    if (start) begin
                        state_d = MC_BUSY;
                        cnt_d   = CNT_LD;
                    end else begin
                        state_d = MC_IDLE;
                    end
                end
                default: state_d = MC_IDLE;
            endcase
        end
    end

    assign busy = (state_q == MC_BUSY);
    assign done = (state_q == MC_DONE);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: per-register pending-write scoreboard, RAW and
// saturation stall detection, and the pipeline stall vector.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_NUM   = 32,
    parameter int unsigned PEND_W    = 2,
    parameter int unsigned MC_CYCLES = 4,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    id_hazard_ctrl_if.slave bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0]  pend_q [REG_NUM];
    logic [PEND_W-1:0]  pend_d [REG_NUM];
    logic [PEND_W-1:0]  pend1, pend2, pendw;
    logic [REG_NUM-1:0] inc_v, dec_v;
    logic               byp1, byp2, src1_hit, src2_hit, sat_hit;
    logic               hazard, issue, mc_busy, mc_done, mc_start;
    logic [STALL_W-1:0] stall;

    always_comb begin
        pend1 = pend_q[bus.id_rd_addr1_in];
        pend2 = pend_q[bus.id_rd_addr2_in];
        pendw = pend_q[bus.id_wr_addr_in];
        // A retire of the last outstanding writer this cycle satisfies the read.
        byp1 = (WB_BYPASS != 0) && bus.wb_wr_en_in &&
               (bus.wb_wr_addr_in == bus.id_rd_addr1_in) && (pend1 == PEND_ONE);
        byp2 = (WB_BYPASS != 0) && bus.wb_wr_en_in &&
               (bus.wb_wr_addr_in == bus.id_rd_addr2_in) && (pend2 == PEND_ONE);
        src1_hit = bus.id_rd_en1_in && (bus.id_rd_addr1_in != '0) && (pend1 != '0) && !byp1;
        src2_hit = bus.id_rd_en2_in && (bus.id_rd_addr2_in != '0) && (pend2 != '0) && !byp2;
        sat_hit  = bus.id_wr_en_in && (bus.id_wr_addr_in != '0) && (pendw == PEND_MAX) &&
                   !(bus.wb_wr_en_in && (bus.wb_wr_addr_in == bus.id_wr_addr_in));
        hazard   = bus.id_valid_in && (src1_hit || src2_hit || sat_hit) && !mc_busy && !mc_done;

        if (bus.flush_in)  stall = STALL_NONE;
        else if (mc_busy)  stall = STALL_MC;
        else if (hazard)   stall = STALL_HAZ;
        else               stall = STALL_NONE;

        // rst_n gates issue so every output reads 0 while reset is held.
        issue    = rst_n && bus.id_valid_in && !bus.flush_in && !stall[2];
        mc_start = issue && bus.id_mc_req_in;
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 0; r < REG_NUM; r++) begin
            inc_v[r] = issue && bus.id_wr_en_in && (bus.id_wr_addr_in == REG_ADDR_WIDTH'(r));
            dec_v[r] = bus.wb_wr_en_in && (bus.wb_wr_addr_in == REG_ADDR_WIDTH'(r)) &&
                       (pend_q[r] != '0);
            pend_d[r] = pend_q[r];
            if (bus.flush_in || r == 0)     pend_d[r] = '0;
            else if (inc_v[r] && !dec_v[r]) pend_d[r] = pend_q[r] + PEND_ONE;
            else if (dec_v[r] && !inc_v[r]) pend_d[r] = pend_q[r] - PEND_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_NUM; r++) pend_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < REG_NUM; r++) pend_q[r] <= pend_d[r];
        end
    end

    id_hazard_ctrl_mc_seq #(
        .MC_CYCLES(MC_CYCLES)
    ) u_mc_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mc_start),
        .flush (bus.flush_in),
        .busy  (mc_busy),
        .done  (mc_done)
    );

    assign bus.stall_out    = stall;
    assign bus.id_issue_out = issue;
    assign bus.hazard_out   = hazard;
    assign bus.mc_busy_out  = mc_busy;
    assign bus.mc_done_out  = mc_done;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural scoreboard model.
module tb_id_hazard_ctrl;

    localparam int MC = 4;
    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SH = 6'b000111;
    localparam logic [5:0] SM = 6'b001111;

    typedef struct packed {
        logic       v;
        logic       e1;
        logic [4:0] a1;
        logic       e2;
        logic [4:0] a2;
        logic       we;
        logic [4:0] wa;
        logic       mc;
        logic       wbe;
        logic [4:0] wba;
        logic       fl;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_hazard_ctrl_if bus();

    id_hazard_ctrl #(
        .REG_NUM  (32),
        .PEND_W   (2),
        .MC_CYCLES(MC),
        .WB_BYPASS(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    stim_t s;
    logic [9:0] want;
    logic [9:0] obs;
    // {stall[5:0], issue, hazard, busy, done}
    assign obs = {bus.stall_out, bus.id_issue_out, bus.hazard_out, bus.mc_busy_out, bus.mc_done_out};

    task automatic drive(input stim_t x);
        bus.id_valid_in    = x.v;
        bus.id_rd_en1_in   = x.e1;
        bus.id_rd_addr1_in = x.a1;
        bus.id_rd_en2_in   = x.e2;
        bus.id_rd_addr2_in = x.a2;
        bus.id_wr_en_in    = x.we;
        bus.id_wr_addr_in  = x.wa;
        bus.id_mc_req_in   = x.mc;
        bus.wb_wr_en_in    = x.wbe;
        bus.wb_wr_addr_in  = x.wba;
        bus.flush_in       = x.fl;
    endtask

    task automatic cyc(input stim_t x);
        drive(x);
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive('0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 3; s.we = 1; s.wa = 3; s.mc = 1;
        rst_n = 1'b0;
        drive(s);
        #2;
        want = '0;
        total++; if (obs !== want) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs, want); end
        @(posedge clk); #1;
        total++; if (obs !== want) begin bad++; $display("FAIL reset_held: got %b want %b", obs, want); end
        do_reset();
    endtask

    task automatic test_raw();
        do_reset();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 1; s.we = 1; s.wa = 3;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL raw_ori_issue: got %b want %b", obs, want); end
        adv();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 1;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL raw_indep_issue: got %b want %b", obs, want); end
        adv();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 3; s.e2 = 1; s.a2 = 3;
        for (int i = 0; i < 3; i++) begin
            cyc(s); want = {SH, 4'b0100};
            total++; if (obs !== want) begin bad++; $display("FAIL raw_stall c%0d: got %b want %b", i, obs, want); end
            adv();
        end
        s.wbe = 1; s.wba = 3;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL raw_bypass: got %b want %b", obs, want); end
        adv();
        s.wbe = 0;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL raw_cleared: got %b want %b", obs, want); end
        adv();
    endtask

    task automatic test_r0();
        do_reset();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 0; s.e2 = 1; s.a2 = 0; s.we = 1; s.wa = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(s); want = {S0, 4'b1000};
            total++; if (obs !== want) begin bad++; $display("FAIL r0_never c%0d: got %b want %b", i, obs, want); end
            adv();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        s = '0; s.v = 1; s.we = 1; s.wa = 5;
        for (int i = 0; i < 3; i++) begin
            cyc(s); want = {S0, 4'b1000};
            total++; if (obs !== want) begin bad++; $display("FAIL sat_fill c%0d: got %b want %b", i, obs, want); end
            adv();
        end
        for (int i = 0; i < 2; i++) begin
            cyc(s); want = {SH, 4'b0100};
            total++; if (obs !== want) begin bad++; $display("FAIL sat_stall c%0d: got %b want %b", i, obs, want); end
            adv();
        end
        s.wbe = 1; s.wba = 5;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL sat_retire_issue: got %b want %b", obs, want); end
        adv();
        s.wbe = 0;
        cyc(s); want = {SH, 4'b0100};
        total++; if (obs !== want) begin bad++; $display("FAIL sat_net_zero: got %b want %b", obs, want); end
        adv();
        s = '0; s.wbe = 1; s.wba = 5;
        cyc(s); want = {S0, 4'b0000};
        total++; if (obs !== want) begin bad++; $display("FAIL sat_retire_only: got %b want %b", obs, want); end
        adv();
        s = '0; s.v = 1; s.we = 1; s.wa = 5;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL sat_after_drop: got %b want %b", obs, want); end
        adv();
    endtask

    task automatic test_mc();
        do_reset();
        s = '0; s.v = 1; s.mc = 1;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL mc_start: got %b want %b", obs, want); end
        adv();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 1;
        for (int i = 1; i <= MC; i++) begin
            cyc(s); want = {SM, 4'b0010};
            total++; if (obs !== want) begin bad++; $display("FAIL mc_busy t+%0d: got %b want %b", i, obs, want); end
            adv();
        end
        s = '0;
        cyc(s); want = {S0, 4'b0001};
        total++; if (obs !== want) begin bad++; $display("FAIL mc_done: got %b want %b", obs, want); end
        adv();
        cyc(s); want = {S0, 4'b0000};
        total++; if (obs !== want) begin bad++; $display("FAIL mc_idle: got %b want %b", obs, want); end
        adv();
    endtask

    task automatic test_back_to_back();
        do_reset();
        s = '0; s.v = 1; s.mc = 1;
        cyc(s); adv();
        for (int i = 0; i < MC; i++) begin cyc(s); adv(); end
        cyc(s); want = {S0, 4'b1001};
        total++; if (obs !== want) begin bad++; $display("FAIL b2b_done_issue: got %b want %b", obs, want); end
        adv();
        s = '0;
        for (int i = 1; i <= MC; i++) begin
            cyc(s); want = {SM, 4'b0010};
            total++; if (obs !== want) begin bad++; $display("FAIL b2b_busy t+%0d: got %b want %b", i, obs, want); end
            adv();
        end
        cyc(s); want = {S0, 4'b0001};
        total++; if (obs !== want) begin bad++; $display("FAIL b2b_done2: got %b want %b", obs, want); end
        adv();
    endtask

    task automatic test_flush();
        do_reset();
        s = '0; s.v = 1; s.we = 1; s.wa = 7;
        cyc(s); adv();
        cyc(s); adv();
        s = '0; s.v = 1; s.mc = 1;
        cyc(s); adv();
        s = '0; s.v = 1; s.e1 = 1; s.a1 = 7;
        cyc(s); want = {SM, 4'b0010};
        total++; if (obs !== want) begin bad++; $display("FAIL flush_busy1: got %b want %b", obs, want); end
        adv();
        s.fl = 1;
        cyc(s); want = {S0, 4'b0010};
        total++; if (obs !== want) begin bad++; $display("FAIL flush_cycle: got %b want %b", obs, want); end
        adv();
        s.fl = 0;
        cyc(s); want = {S0, 4'b1000};
        total++; if (obs !== want) begin bad++; $display("FAIL flush_after: got %b want %b", obs, want); end
        adv();
        s = '0; s.v = 1; s.mc = 1;
        cyc(s); adv();
        s = '0; s.v = 1;
        cyc(s); want = {SM, 4'b0010};
        total++; if (obs !== want) begin bad++; $display("FAIL rst_prebusy: got %b want %b", obs, want); end
        rst_n = 1'b0;
        #1;
        want = '0;
        total++; if (obs !== want) begin bad++; $display("FAIL rst_midbusy: got %b want %b", obs, want); end
        adv();
        do_reset();
    endtask

    task automatic test_random();
        int         pend_m[32];
        int         mc_left;
        bit         done_m;
        bit         idle_m, h1, h2, sat, haz_e, iss_e;
        logic [5:0] stall_e;
        for (int r = 0; r < 32; r++) pend_m[r] = 0;
        mc_left = 0;
        done_m  = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            s.v   = 1'($urandom_range(0, 3) != 0);
            s.e1  = 1'($urandom_range(0, 1));
            s.a1  = 5'($urandom_range(0, 7));
            s.e2  = 1'($urandom_range(0, 1));
            s.a2  = 5'($urandom_range(0, 7));
            s.we  = 1'($urandom_range(0, 1));
            s.wa  = 5'($urandom_range(0, 7));
            s.mc  = 1'($urandom_range(0, 15) == 0);
            s.wbe = 1'($urandom_range(0, 1));
            s.wba = 5'($urandom_range(0, 7));
            s.fl  = 1'($urandom_range(0, 39) == 0);
            cyc(s);

            idle_m = (mc_left == 0) && !done_m;
            h1  = s.e1 && s.a1 != 0 && pend_m[s.a1] != 0 && !(s.wbe && s.wba == s.a1 && pend_m[s.a1] == 1);
            h2  = s.e2 && s.a2 != 0 && pend_m[s.a2] != 0 && !(s.wbe && s.wba == s.a2 && pend_m[s.a2] == 1);
            sat = s.we && s.wa != 0 && pend_m[s.wa] == 3 && !(s.wbe && s.wba == s.wa);
            haz_e = s.v && (h1 || h2 || sat) && idle_m;
            if (s.fl)             stall_e = S0;
            else if (mc_left > 0) stall_e = SM;
            else if (haz_e)       stall_e = SH;
            else                  stall_e = S0;
            iss_e = s.v && !s.fl && !stall_e[2];

            total++; if (bus.stall_out !== stall_e) begin bad++; $display("FAIL rnd_stall n%0d: got %b want %b", n, bus.stall_out, stall_e); end
            total++; if (bus.id_issue_out !== iss_e) begin bad++; $display("FAIL rnd_issue n%0d: got %b want %b", n, bus.id_issue_out, iss_e); end
            total++; if (bus.hazard_out !== haz_e) begin bad++; $display("FAIL rnd_hazard n%0d: got %b want %b", n, bus.hazard_out, haz_e); end
            total++; if (bus.mc_busy_out !== (mc_left > 0)) begin bad++; $display("FAIL rnd_busy n%0d: got %b want %b", n, bus.mc_busy_out, (mc_left > 0)); end
            total++; if (bus.mc_done_out !== done_m) begin bad++; $display("FAIL rnd_done n%0d: got %b want %b", n, bus.mc_done_out, done_m); end

            if (s.fl) begin
                for (int r = 0; r < 32; r++) pend_m[r] = 0;
                mc_left = 0;
                done_m  = 0;
            end else begin
                if (s.wbe && s.wba != 0 && pend_m[s.wba] != 0) pend_m[s.wba] -= 1;
                if (iss_e && s.we && s.wa != 0) pend_m[s.wa] = (pend_m[s.wa] + 1) % 4;
                if (mc_left > 0) begin
                    mc_left -= 1;
                    done_m = (mc_left == 0);
                end else if (iss_e && s.mc) begin
                    mc_left = MC;
                    done_m  = 0;
                end else begin
                    done_m = 0;
                end
            end
            adv();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s = '0;
        drive(s);
        test_reset();
        test_raw();
        test_r0();
        test_saturation();
        test_mc();
        test_back_to_back();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
